sun_tr_regbank: RTL

SUN_TR_REGBANK -- requirements
Module: sun_tr_regbank

---
 rtl/sun_tr_pkg.sv | 19 +
 rtl/sun_tr_dff_bit.sv | 33 +++
 rtl/sun_tr_regbank.sv | 102 ++++++++++
 3 files changed

// File: rtl/sun_tr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sun_tr_pkg                                                |
// | Brief    : Shared MODE encoding for the sun_tr register bank.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sun_tr_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

endpackage : sun_tr_pkg
`default_nettype wire

// File: rtl/sun_tr_dff_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sun_tr_dff_bit                                            |
// | Brief    : Single storage bit with synchronous reset and set.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sun_tr_dff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Reset dominates set; both are sampled only on the rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RESET_BIT;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : sun_tr_dff_bit
`default_nettype wire

// File: rtl/sun_tr_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sun_tr_regbank                                            |
// | Brief    : Hold/load/shift/count register bank with wrap flag.       |
// |            Optional scan chain enabled by macro SUN_TR_SCAN_EN.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sun_tr_regbank
    import sun_tr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CK,
    input  logic              R,
    input  logic              S,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SIN,
`ifdef SUN_TR_SCAN_EN
    input  logic              SE,
    input  logic              SI,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic              SOUT,
    output logic              CO
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_co_next;
    logic             w_scan_en;
    logic             w_scan_in;
    logic             w_wrap;
    mode_e            w_mode;
    logic             r_co;

`ifdef SUN_TR_SCAN_EN
    assign w_scan_en = SE;
    assign w_scan_in = SI;
`else
    assign w_scan_en = 1'b0;
    assign w_scan_in = 1'b0;
`endif

    assign w_mode = mode_e'(MODE);
    assign w_wrap = &w_q;

    // R and S are applied inside each bit flop; this mux covers the rest.
    always_comb begin
        w_q_next  = w_q;
        w_co_next = 1'b0;
        if (w_scan_en) begin
            w_q_next = {w_q[WIDTH-2:0], w_scan_in};
        end else if (EN) begin
            case (w_mode)
                MODE_HOLD:  w_q_next = w_q;
                MODE_LOAD:  w_q_next = D;
                MODE_SHIFT: w_q_next = {w_q[WIDTH-2:0], SIN};
                MODE_COUNT: begin
                    w_q_next  = w_q + c_one;
                    w_co_next = w_wrap;
                end
                default:    w_q_next = w_q;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            sun_tr_dff_bit #(
                .RESET_BIT (RESET_VAL[i])
            ) u_bit (
                .i_clk (CK),
                .i_rst (R),
                .i_set (S),
                .i_d   (w_q_next[i]),
                .o_q   (w_q[i])
            );
        end
    endgenerate

    // Wrap flag: any reset, set, or scan cycle forces it low.
    always_ff @(posedge CK) begin
        if (R || S) begin
            r_co <= 1'b0;
        end else begin
            r_co <= w_co_next;
        end
    end

    assign Q    = w_q;
    assign QN   = ~w_q;
    assign SOUT = w_q[WIDTH-1];
    assign CO   = r_co;

endmodule : sun_tr_regbank
`default_nettype wire
